// File: rtl/slot_allocator_pkg.sv
// slot_allocator_pkg: FSM encoding and width-derivation helpers for the slot allocator.
package slot_allocator_pkg;
  typedef enum logic {IDLE, RUN} state_e;
  function automatic int clog2(input int v);
    for (int r = 0; r < 31; r++) if ((1 << r) >= v) return r;
    return 31;
  endfunction
  function automatic bit widths_ok(input int slots, input int iw, input int cw);
    return slots >= 2 && iw == clog2(slots) && cw == clog2(slots + 1);
  endfunction
endpackage

// File: rtl/Bitmask_Thermometer_to_Rightmost_0_Bit.sv
// Bitmask_Thermometer_to_Rightmost_0_Bit: sets every bit from bit 0 up to and including the lowest 0 bit.
module Bitmask_Thermometer_to_Rightmost_0_Bit #(
  parameter int WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] word_in,
  output logic [WORD_WIDTH-1:0] word_out
);
  assign word_out = word_in ^ (word_in + WORD_WIDTH'(1));
endmodule

// File: rtl/slot_allocator.sv
// slot_allocator: owns a pool of slots, offers the lowest free one, accepts releases.
module slot_allocator
  import slot_allocator_pkg::*;
#(
  parameter int SLOT_COUNT  = 8,
  parameter int INDEX_WIDTH = clog2(SLOT_COUNT),
  parameter int COUNT_WIDTH = clog2(SLOT_COUNT + 1)
) (
  input  logic                   clock,
  input  logic                   clear_n,
  output logic                   alloc_valid,
  input  logic                   alloc_ready,
  output logic [SLOT_COUNT-1:0]  alloc_onehot,
  output logic [INDEX_WIDTH-1:0] alloc_index,
  input  logic                   release_valid,
  output logic                   release_ready,
  input  logic [INDEX_WIDTH-1:0] release_index,
  output logic [SLOT_COUNT-1:0]  occupied_mask,
  output logic [COUNT_WIDTH-1:0] free_count,
  output logic                   full,
  output logic                   empty,
  output logic                   release_error
);
  state_e                 state_q, state_d;
  logic [SLOT_COUNT-1:0]  mask_q, mask_d, thermo, lowest_free, rel_onehot;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   err_q, err_d, running, alloc_fire, rel_fire, rel_ok;
  logic [INDEX_WIDTH-1:0] lowest_index;

  Bitmask_Thermometer_to_Rightmost_0_Bit #(.WORD_WIDTH(SLOT_COUNT)) u_thermo (
    .word_in (mask_q),
    .word_out(thermo)
  );

  assign lowest_free = thermo & ~mask_q;
  always_comb begin
    lowest_index = '0;
    for (int i = 0; i < SLOT_COUNT; i++)
      if (lowest_free[i]) lowest_index = lowest_index | INDEX_WIDTH'(i);
  end

  assign running       = state_q == RUN;
  assign full          = count_q == '0;
  assign empty         = count_q == COUNT_WIDTH'(SLOT_COUNT);
  assign alloc_valid   = running & ~full;
  assign alloc_onehot  = alloc_valid ? lowest_free : '0;
  assign alloc_index   = alloc_valid ? lowest_index : '0;
  assign release_ready = running;
  assign occupied_mask = mask_q;
  assign free_count    = count_q;
  assign release_error = err_q;

  // A release of an unowned (including the currently offered) slot is rejected and flagged.
  assign alloc_fire = alloc_valid & alloc_ready;
  assign rel_fire   = release_valid & running;
  assign rel_onehot = SLOT_COUNT'(1) << release_index;
  assign rel_ok     = rel_fire & (int'(release_index) < SLOT_COUNT) & mask_q[release_index];

  always_comb begin
    state_d = running ? RUN : (clear_n ? RUN : IDLE);
    mask_d  = (mask_q | (alloc_fire ? lowest_free : '0)) & ~(rel_ok ? rel_onehot : '0);
    count_d = count_q + COUNT_WIDTH'(rel_ok) - COUNT_WIDTH'(alloc_fire);
    err_d   = err_q | (rel_fire & ~rel_ok);
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      count_q <= COUNT_WIDTH'(SLOT_COUNT);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  a_count_consistent: assert property (@(posedge clock) disable iff (!clear_n)
    widths_ok(SLOT_COUNT, INDEX_WIDTH, COUNT_WIDTH) &&
    count_q == COUNT_WIDTH'(SLOT_COUNT - $countones(mask_q)));
endmodule

// File: tb/tb_slot_allocator.sv
// tb_slot_allocator: directed vector table plus hand sequences for the slot allocator.
module tb_slot_allocator;
  logic       clock = 1'b0;
  logic       clear_n = 1'b0, alloc_ready = 1'b0, release_valid = 1'b0;
  logic [2:0] release_index = '0;
  logic       alloc_valid, release_ready, full, empty, release_error;
  logic [7:0] alloc_onehot, occupied_mask;
  logic [2:0] alloc_index;
  logic [3:0] free_count;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic cn, ar, rv;
    logic [2:0] ri;
    logic ev;
    logic [2:0] ei;
    logic [7:0] em;
    logic [3:0] ec;
    logic ee, er;
  } vec_t;

  slot_allocator dut (
    .clock(clock), .clear_n(clear_n), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_onehot(alloc_onehot), .alloc_index(alloc_index), .release_valid(release_valid),
    .release_ready(release_ready), .release_index(release_index), .occupied_mask(occupied_mask),
    .free_count(free_count), .full(full), .empty(empty), .release_error(release_error)
  );

  always #5 clock = ~clock;

  function automatic vec_t v(logic cn, logic ar, logic rv, logic [2:0] ri, logic ev,
                             logic [2:0] ei, logic [7:0] em, logic [3:0] ec, logic ee, logic er);
    vec_t r;
    r.cn = cn; r.ar = ar; r.rv = rv; r.ri = ri; r.ev = ev;
    r.ei = ei; r.em = em; r.ec = ec; r.ee = ee; r.er = er;
    return r;
  endfunction

  task automatic chk(string nm, int row, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, got, exp);
    end
  endtask

  task automatic apply(vec_t t, int row);
    logic [7:0] oh;
    clear_n = t.cn; alloc_ready = t.ar; release_valid = t.rv; release_index = t.ri;
    @(posedge clock);
    #1;
    oh = t.ev ? (8'h01 << t.ei) : 8'h00;
    chk("alloc_valid", row, 32'(alloc_valid), 32'(t.ev));
    chk("alloc_index", row, 32'(alloc_index), 32'(t.ev ? t.ei : 3'd0));
    chk("alloc_onehot", row, 32'(alloc_onehot), 32'(oh));
    chk("occupied_mask", row, 32'(occupied_mask), 32'(t.em));
    chk("free_count", row, 32'(free_count), 32'(t.ec));
    chk("full", row, 32'(full), 32'(t.ec == 4'd0));
    chk("empty", row, 32'(empty), 32'(t.ec == 4'd8));
    chk("release_error", row, 32'(release_error), 32'(t.ee));
    chk("release_ready", row, 32'(release_ready), 32'(t.er));
  endtask

  initial begin
    vec_t tbl[$];
    //           cn  ar  rv  ri  ev  ei  mask   cnt  err rdy
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 8'h00, 8, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 8'h00, 8, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 1, 8'h01, 7, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 2, 8'h03, 6, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 3, 8'h07, 5, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 4, 8'h0F, 4, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 5, 8'h1F, 3, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 6, 8'h3F, 2, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 7, 8'h7F, 1, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 8'hFF, 0, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 8'hFF, 0, 0, 1));
    tbl.push_back(v(1, 0, 1, 3, 1, 3, 8'hF7, 1, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 8'hFF, 0, 0, 1));
    tbl.push_back(v(1, 0, 1, 5, 1, 5, 8'hDF, 1, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 8'hFF, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 8'h00, 8, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 8'h00, 8, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 1, 8'h01, 7, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 2, 8'h03, 6, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 3, 8'h07, 5, 0, 1));
    tbl.push_back(v(1, 1, 1, 1, 1, 1, 8'h0D, 5, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 4, 8'h0F, 4, 0, 1));
    tbl.push_back(v(1, 0, 1, 6, 1, 4, 8'h0F, 4, 1, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 5, 8'h1F, 3, 1, 1));
    tbl.push_back(v(1, 0, 1, 0, 1, 0, 8'h1E, 4, 1, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 5, 8'h1F, 3, 1, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 6, 8'h3F, 2, 1, 1));
    tbl.push_back(v(1, 1, 0, 0, 1, 7, 8'h7F, 1, 1, 1));
    tbl.push_back(v(1, 0, 1, 0, 1, 0, 8'h7E, 2, 1, 1));
    tbl.push_back(v(1, 0, 1, 2, 1, 0, 8'h7A, 3, 1, 1));
    tbl.push_back(v(1, 0, 1, 5, 1, 0, 8'h5A, 4, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 8'h00, 8, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 8'h00, 8, 0, 1));
    foreach (tbl[i]) apply(tbl[i], i);
    // Alloc of the offered slot 0 while releasing that same slot: grant proceeds, error flagged.
    apply(v(1, 1, 1, 0, 1, 1, 8'h01, 7, 1, 1), 100);
    apply(v(1, 0, 0, 0, 1, 1, 8'h01, 7, 1, 1), 101);
    // Reset, then a release during the idle cycle is not accepted.
    apply(v(0, 0, 0, 0, 0, 0, 8'h00, 8, 0, 0), 200);
    apply(v(1, 1, 1, 0, 1, 0, 8'h00, 8, 0, 1), 201);
    // A stale holder releasing after reset flags an error without touching the mask.
    apply(v(1, 0, 1, 4, 1, 0, 8'h00, 8, 1, 1), 202);
    apply(v(1, 1, 0, 0, 1, 1, 8'h01, 7, 1, 1), 203);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
